// File: rtl/rvfifo_rr_arb.sv
// Round-robin arbiter merging N float ready/valid streams into one registered output slot.
// A granted requester may keep the grant for up to MAXBURST consecutive beats.
module rvfifo_rr_arb #(
    parameter int N        = 2,
    parameter int E        = 8,
    parameter int F        = 23,
    parameter int MAXBURST = 4,
    localparam int SW      = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*F-1:0] s_port_data_frac,
    input  logic [N*E-1:0] s_port_data_expo,
    input  logic [N-1:0]   s_port_data_sign,
    input  logic [N-1:0]   s_port_valid,
    output logic [N-1:0]   s_port_ready,
    output logic [F-1:0]   m_port_data_frac,
    output logic [E-1:0]   m_port_data_expo,
    output logic           m_port_data_sign,
    output logic           m_port_valid,
    input  logic           m_port_ready,
    output logic [SW-1:0]  m_port_src
);

    localparam int CW = $clog2(MAXBURST + 1);

    logic [SW-1:0] cur;
    logic          lock;
    logic [CW-1:0] cnt;

    logic          loadable;
    logic          any_valid;
    logic          hold;
    logic [SW-1:0] sel_rr;
    logic [SW-1:0] sel;
    logic [F-1:0]  sel_frac;
    logic [E-1:0]  sel_expo;
    logic          sel_sign;

    assign loadable  = !m_port_valid || m_port_ready;
    assign any_valid = |s_port_valid;
    assign hold      = lock && s_port_valid[cur] && (cnt < CW'(MAXBURST));
    assign sel       = hold ? cur : sel_rr;

    // Scan from farthest to nearest so the nearest valid after cur wins; cur itself is last.
    always_comb begin
        int idx;
        idx    = 0;
        sel_rr = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(cur) + k) % N;
            if (s_port_valid[idx]) begin
                sel_rr = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        sel_frac = '0;
        sel_expo = '0;
        sel_sign = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                sel_frac = s_port_data_frac[i*F +: F];
                sel_expo = s_port_data_expo[i*E +: E];
                sel_sign = s_port_data_sign[i];
            end
        end
    end

    assign s_port_ready = (!reset && loadable && any_valid) ? (N'(1) << sel) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_port_valid     <= 1'b0;
            m_port_data_frac <= '0;
            m_port_data_expo <= '0;
            m_port_data_sign <= 1'b0;
            m_port_src       <= '0;
            cur              <= SW'(N - 1);
            lock             <= 1'b0;
            cnt              <= '0;
        end else if (loadable) begin
            if (any_valid) begin
                m_port_valid     <= 1'b1;
                m_port_data_frac <= sel_frac;
                m_port_data_expo <= sel_expo;
                m_port_data_sign <= sel_sign;
                m_port_src       <= sel;
                if (lock && (sel == cur) && (cnt < CW'(MAXBURST))) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    cur  <= sel;
                    cnt  <= CW'(1);
                    lock <= 1'b1;
                end
            end else begin
                // Idle drops the burst but keeps cur so rotation resumes fairly.
                m_port_valid <= 1'b0;
                lock         <= 1'b0;
                cnt          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rvfifo_rr_arb.sv
// Directed scoreboard bench for rvfifo_rr_arb: a 2-requester burst instance and a
// 3-requester pure round-robin instance share one clock and reset.
module tb_rvfifo_rr_arb;

    typedef struct packed {
        logic [1:0]  src;
        logic        sign;
        logic [7:0]  expo;
        logic [22:0] frac;
    } beat_t;

    logic clk = 1'b0;
    logic reset;

    logic [45:0] frac2;
    logic [15:0] expo2;
    logic [1:0]  sign2, v2, sr2;
    logic [22:0] mf2;
    logic [7:0]  me2;
    logic        ms2, mv2, mr2;
    logic [0:0]  src2;

    logic [68:0] frac3;
    logic [23:0] expo3;
    logic [2:0]  sign3, v3, sr3;
    logic [22:0] mf3;
    logic [7:0]  me3;
    logic        ms3, mv3, mr3;
    logic [1:0]  src3;

    beat_t q2[$];
    beat_t q3[$];
    int    k[2][3];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    rvfifo_rr_arb #(.N(2), .E(8), .F(23), .MAXBURST(4)) dut2 (
        .clk(clk), .reset(reset),
        .s_port_data_frac(frac2), .s_port_data_expo(expo2), .s_port_data_sign(sign2),
        .s_port_valid(v2), .s_port_ready(sr2),
        .m_port_data_frac(mf2), .m_port_data_expo(me2), .m_port_data_sign(ms2),
        .m_port_valid(mv2), .m_port_ready(mr2), .m_port_src(src2)
    );

    rvfifo_rr_arb #(.N(3), .E(8), .F(23), .MAXBURST(1)) dut3 (
        .clk(clk), .reset(reset),
        .s_port_data_frac(frac3), .s_port_data_expo(expo3), .s_port_data_sign(sign3),
        .s_port_valid(v3), .s_port_ready(sr3),
        .m_port_data_frac(mf3), .m_port_data_expo(me3), .m_port_data_sign(ms3),
        .m_port_valid(mv3), .m_port_ready(mr3), .m_port_src(src3)
    );

    task automatic applyStimulus(input int which, input logic rst, input logic [2:0] valid,
                                 input logic mready);
        @(posedge clk);
        #1;
        reset = rst;
        if (which == 0) begin
            v2  = valid[1:0];
            mr2 = mready;
        end else begin
            v3  = valid;
            mr3 = mready;
        end
        for (int i = 0; i < 2; i++) begin
            frac2[i*23 +: 23] = 23'(256 * i + k[0][i]);
            expo2[i*8 +: 8]   = 8'(k[0][i]);
            sign2[i]          = 1'(i);
        end
        for (int i = 0; i < 3; i++) begin
            frac3[i*23 +: 23] = 23'(256 * i + k[1][i]);
            expo3[i*8 +: 8]   = 8'(k[1][i]);
            sign3[i]          = 1'(i);
        end
    endtask

    // Scoreboard occupancy predicts m_port_valid; the front entry must match the slot.
    task automatic checkOutput(input int which, input logic [2:0] exp_ready, input string tag);
        beat_t      obs;
        beat_t      front;
        beat_t      exp_beat;
        logic       mv, mr;
        logic [2:0] sr;
        int         qsize;
        int         idx;
        @(negedge clk);
        if (which == 0) begin
            mv  = mv2;
            mr  = mr2;
            sr  = {1'b0, sr2};
            obs = '{src: {1'b0, src2}, sign: ms2, expo: me2, frac: mf2};
            qsize = q2.size();
        end else begin
            mv  = mv3;
            mr  = mr3;
            sr  = sr3;
            obs = '{src: src3, sign: ms3, expo: me3, frac: mf3};
            qsize = q3.size();
        end

        checks++;
        assert (mv === (qsize != 0)) else begin
            errors++;
            $error("[TB] FAIL %s m_port_valid: observed %b expected %b", tag, mv, (qsize != 0));
        end

        if (mv === 1'b1 && qsize != 0) begin
            front = (which == 0) ? q2[0] : q3[0];
            checks++;
            assert (obs === front) else begin
                errors++;
                $error("[TB] FAIL %s beat {src,sign,expo,frac}: observed %h expected %h",
                       tag, obs, front);
            end
            if (mr === 1'b1) begin
                if (which == 0) void'(q2.pop_front());
                else            void'(q3.pop_front());
            end
        end

        checks++;
        assert (sr === exp_ready) else begin
            errors++;
            $error("[TB] FAIL %s s_port_ready: observed %b expected %b", tag, sr, exp_ready);
        end

        if (exp_ready != 3'b000) begin
            idx = 0;
            for (int i = 0; i < 3; i++) begin
                if (exp_ready[i]) idx = i;
            end
            exp_beat = '{src: 2'(idx), sign: 1'(idx), expo: 8'(k[which][idx]),
                         frac: 23'(256 * idx + k[which][idx])};
            if (which == 0) q2.push_back(exp_beat);
            else            q3.push_back(exp_beat);
            k[which][idx]++;
        end
    endtask

    initial begin
        reset = 1'b1;
        v2 = '0; mr2 = 1'b1; frac2 = '0; expo2 = '0; sign2 = '0;
        v3 = '0; mr3 = 1'b1; frac3 = '0; expo3 = '0; sign3 = '0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 3; i++) k[w][i] = 0;
        end

        repeat (2) begin
            applyStimulus(0, 1'b1, 3'b011, 1'b1);
            checkOutput(0, 3'b000, "reset_hold");
        end

        // Requester 0 first after reset, then alternating bursts of four.
        for (int b = 0; b < 16; b++) begin
            applyStimulus(0, 1'b0, 3'b011, 1'b1);
            checkOutput(0, (((b / 4) % 2) != 0) ? 3'b010 : 3'b001, "rr_burst");
        end

        for (int b = 0; b < 10; b++) begin
            applyStimulus(0, 1'b0, 3'b010, 1'b1);
            checkOutput(0, 3'b010, "solo_req1");
        end

        repeat (2) begin
            applyStimulus(0, 1'b0, 3'b000, 1'b1);
            checkOutput(0, 3'b000, "idle_a");
        end

        applyStimulus(0, 1'b0, 3'b001, 1'b1);
        checkOutput(0, 3'b001, "load_before_stall");
        repeat (3) begin
            applyStimulus(0, 1'b0, 3'b011, 1'b0);
            checkOutput(0, 3'b000, "stall_hold");
        end
        applyStimulus(0, 1'b0, 3'b011, 1'b1);
        checkOutput(0, 3'b001, "drain_and_load");

        applyStimulus(0, 1'b0, 3'b010, 1'b1);
        checkOutput(0, 3'b010, "drop_switch");
        repeat (3) begin
            applyStimulus(0, 1'b0, 3'b011, 1'b1);
            checkOutput(0, 3'b010, "burst_lock");
        end
        applyStimulus(0, 1'b0, 3'b011, 1'b1);
        checkOutput(0, 3'b001, "regrant_req0");
        repeat (2) begin
            applyStimulus(0, 1'b0, 3'b000, 1'b1);
            checkOutput(0, 3'b000, "idle_b");
        end

        for (int b = 0; b < 6; b++) begin
            applyStimulus(1, 1'b0, 3'b111, 1'b1);
            checkOutput(1, 3'(1 << (b % 3)), "rr3_pure");
        end
        repeat (2) begin
            applyStimulus(1, 1'b0, 3'b111, 1'b0);
            checkOutput(1, 3'b000, "rr3_stall");
        end
        applyStimulus(1, 1'b1, 3'b111, 1'b0);
        checkOutput(1, 3'b000, "rr3_reset");
        q3.delete();
        applyStimulus(1, 1'b0, 3'b111, 1'b1);
        checkOutput(1, 3'b001, "rr3_after_reset");
        repeat (2) begin
            applyStimulus(1, 1'b0, 3'b000, 1'b1);
            checkOutput(1, 3'b000, "rr3_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
